// File: rtl/stopwatch_display_mux_if.sv
// Interface between the stopwatch counter/controller and the display mux.
//   i_en, i_hold         : display enable and lap hold
//   i_hr_0 .. i_sec_3    : eight BCD digits, leftmost (tens of hours) to rightmost (hundredths)
//   o_an, o_seg, o_dp    : multiplexed seven-segment drive (polarity set by the mux)
// master = the side that drives the digits; slave = the display mux.
interface stopwatch_display_mux_if;
  logic       i_en;
  logic       i_hold;
  logic [3:0] i_hr_0;
  logic [3:0] i_hr_1;
  logic [3:0] i_min_0;
  logic [3:0] i_min_1;
  logic [3:0] i_sec_0;
  logic [3:0] i_sec_1;
  logic [3:0] i_sec_2;
  logic [3:0] i_sec_3;
  logic [7:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp;

  modport master (
    output i_en, i_hold, i_hr_0, i_hr_1, i_min_0, i_min_1,
           i_sec_0, i_sec_1, i_sec_2, i_sec_3,
    input  o_an, o_seg, o_dp
  );

  modport slave (
    input  i_en, i_hold, i_hr_0, i_hr_1, i_min_0, i_min_1,
           i_sec_0, i_sec_1, i_sec_2, i_sec_3,
    output o_an, o_seg, o_dp
  );
endinterface

// File: rtl/stopwatch_display_mux.sv
// Eight-digit multiplexed seven-segment driver for the stopwatch counter.
// Scans one digit per SCAN_DIV clocks, decodes BCD to segments (dash for >9), blanks a
// leading zero hour, lights decimal points as hh.mm.ss.cc and freezes the value on lap hold.
// The eight digits are snapshotted only at frame boundaries so a frame never mixes counts.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : stopwatch_display_mux_if.slave (enable, hold, digits in; an/seg/dp out)
module stopwatch_display_mux #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned D_width   = 16,
  parameter bit          COM_ANODE = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  stopwatch_display_mux_if.slave  bus
);

  localparam logic [D_width-1:0] LP_LAST    = D_width'(SCAN_DIV - 1);
  localparam logic [7:0]         LP_AN_OFF  = COM_ANODE ? 8'hFF : 8'h00;
  localparam logic [6:0]         LP_SEG_OFF = COM_ANODE ? 7'h7F : 7'h00;
  localparam logic               LP_DP_OFF  = COM_ANODE;

  logic [D_width-1:0] r_presc, w_presc_d;
  logic [2:0]         r_idx, w_idx_d;
  logic [31:0]        r_snap, w_snap_d;
  logic [7:0]         r_an, w_an_d;
  logic [6:0]         r_seg, w_seg_d;
  logic               r_dp, w_dp_d;

  logic               w_tick, w_snap_ld;
  logic [3:0]         w_digit;
  logic [6:0]         w_seg_hi;
  logic               w_dp_hi;
  logic [7:0]         w_an_hi;

  // Prescaler and digit index; disable forces both back to the start of a fresh slot.
  always_comb begin
    w_tick    = bus.i_en && (r_presc == LP_LAST);
    w_presc_d = r_presc + 1'b1;
    w_idx_d   = r_idx;
    if (!bus.i_en) begin
      w_presc_d = '0;
      w_idx_d   = 3'd0;
    end else if (w_tick) begin
      w_presc_d = '0;
      w_idx_d   = r_idx + 3'd1;
    end
  end

  // Snapshot loads only when the index wraps 7->0 (or every cycle while disabled);
  // hold overrides both.
  always_comb begin
    w_snap_ld = !bus.i_hold && (!bus.i_en || (w_tick && (r_idx == 3'd7)));
    w_snap_d  = r_snap;
    if (w_snap_ld) begin
      w_snap_d = {bus.i_hr_0, bus.i_hr_1, bus.i_min_0, bus.i_min_1,
                  bus.i_sec_0, bus.i_sec_1, bus.i_sec_2, bus.i_sec_3};
    end
  end

  // Digit select and decode, in active-high form.
  always_comb begin
    w_digit = 4'd0;
    unique case (r_idx)
      3'd0: w_digit = r_snap[31:28];
      3'd1: w_digit = r_snap[27:24];
      3'd2: w_digit = r_snap[23:20];
      3'd3: w_digit = r_snap[19:16];
      3'd4: w_digit = r_snap[15:12];
      3'd5: w_digit = r_snap[11:8];
      3'd6: w_digit = r_snap[7:4];
      3'd7: w_digit = r_snap[3:0];
      default: w_digit = 4'd0;
    endcase

    case (w_digit)
      4'd0:    w_seg_hi = 7'h3F;
      4'd1:    w_seg_hi = 7'h06;
      4'd2:    w_seg_hi = 7'h5B;
      4'd3:    w_seg_hi = 7'h4F;
      4'd4:    w_seg_hi = 7'h66;
      4'd5:    w_seg_hi = 7'h6D;
      4'd6:    w_seg_hi = 7'h7D;
      4'd7:    w_seg_hi = 7'h07;
      4'd8:    w_seg_hi = 7'h7F;
      4'd9:    w_seg_hi = 7'h6F;
      default: w_seg_hi = 7'h40;
    endcase
    // Leading zero of the hours is blanked but the digit is still scanned.
    if ((r_idx == 3'd0) && (w_digit == 4'd0)) begin
      w_seg_hi = 7'h00;
    end

    w_dp_hi = (r_idx == 3'd1) || (r_idx == 3'd3) || (r_idx == 3'd5);
    w_an_hi = 8'h01 << r_idx;
  end

  always_comb begin
    w_an_d  = LP_AN_OFF;
    w_seg_d = LP_SEG_OFF;
    w_dp_d  = LP_DP_OFF;
    if (bus.i_en) begin
      w_an_d  = COM_ANODE ? ~w_an_hi  : w_an_hi;
      w_seg_d = COM_ANODE ? ~w_seg_hi : w_seg_hi;
      w_dp_d  = COM_ANODE ? ~w_dp_hi  : w_dp_hi;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
      r_snap  <= '0;
      r_an    <= LP_AN_OFF;
      r_seg   <= LP_SEG_OFF;
      r_dp    <= LP_DP_OFF;
    end else begin
      r_presc <= w_presc_d;
      r_idx   <= w_idx_d;
      r_snap  <= w_snap_d;
      r_an    <= w_an_d;
      r_seg   <= w_seg_d;
      r_dp    <= w_dp_d;
    end
  end

  assign bus.o_an  = r_an;
  assign bus.o_seg = r_seg;
  assign bus.o_dp  = r_dp;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Self-checking bench for stopwatch_display_mux (SCAN_DIV=4, common anode).
// Expected slots are queued when digits are driven; a monitor pops one entry at the start
// of every new digit slot and compares an/seg/dp.
module tb_stopwatch_display_mux;
  localparam int unsigned SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_display_mux_if bus ();

  stopwatch_display_mux #(
    .SCAN_DIV  (SCAN_DIV),
    .D_width   (16),
    .COM_ANODE (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [31:0]         dig;
    logic [0:7][6:0]     seg;  // active-high segments, index 0 first
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[5];
  logic [6:0] lut[16];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_digits(input logic [31:0] d);
    bus.i_hr_0  = d[31:28];
    bus.i_hr_1  = d[27:24];
    bus.i_min_0 = d[23:20];
    bus.i_min_1 = d[19:16];
    bus.i_sec_0 = d[15:12];
    bus.i_sec_1 = d[11:8];
    bus.i_sec_2 = d[7:4];
    bus.i_sec_3 = d[3:0];
  endtask

  function automatic logic [0:7][6:0] model_segs(input logic [31:0] d);
    logic [0:7][6:0] r;
    logic [3:0]      v;
    for (int k = 0; k < 8; k++) begin
      v    = d[4*(7-k) +: 4];
      r[k] = ((k == 0) && (v == 4'd0)) ? 7'h00 : lut[v];
    end
    return r;
  endfunction

  task automatic push_frame(input logic [0:7][6:0] s);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.an  = ~(8'h01 << k);
      e.seg = ~s[k];
      e.dp  = !((k == 1) || (k == 3) || (k == 5));
      sb.push_back(e);
    end
  endtask

  // Returns on the first negedge where o_an newly equals an_v.
  task automatic wait_slot_start(input logic [7:0] an_v, input string name);
    logic [7:0] prev;
    prev = bus.o_an;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((bus.o_an === an_v) && (prev !== an_v)) begin
        checks++;
        return;
      end
      prev = bus.o_an;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for o_an=%h, got %h", name, an_v, bus.o_an);
  endtask

  task automatic wait_sb(input int n, input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() <= n) begin
        checks++;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout, %0d slots still expected (wanted <= %0d)", name, sb.size(), n);
    sb.delete();
  endtask

  // Slot monitor
  initial begin : mon
    logic [7:0] prev;
    exp_t       e;
    prev = 8'hFF;
    forever begin
      @(negedge clk);
      if ((bus.o_an !== prev) && (bus.o_an !== 8'hFF) && (sb.size() > 0)) begin
        e = sb.pop_front();
        chk("slot_an", bus.o_an, e.an);
        chk("slot_seg", bus.o_seg, e.seg);
        chk("slot_dp", bus.o_dp, e.dp);
      end
      prev = bus.o_an;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F;
    lut[4] = 7'h66; lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07;
    lut[8] = 7'h7F; lut[9] = 7'h6F;
    for (int i = 10; i < 16; i++) lut[i] = 7'h40;

    vecs[0] = '{dig: 32'h12345678,
                seg: {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F}};
    vecs[1] = '{dig: 32'h12345679,
                seg: {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h6F}};
    vecs[2] = '{dig: 32'h00001000,
                seg: {7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F}};
    vecs[3] = '{dig: 32'h09CFA082,
                seg: {7'h00, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h7F, 7'h5B}};
    vecs[4] = '{dig: 32'h50000000,
                seg: {7'h6D, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};

    bus.i_en   = 1'b1;
    bus.i_hold = 1'b0;
    set_digits(32'h0);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_an", bus.o_an, 8'hFF);
    chk("reset_seg", bus.o_seg, 7'h7F);
    chk("reset_dp", bus.o_dp, 1'b1);
    rst_n = 1'b1;

    // Table-driven frames: digits driven during slot 7, shown in the next frame.
    foreach (vecs[i]) begin
      wait_slot_start(8'h7F, "vec_align");
      set_digits(vecs[i].dig);
      push_frame(vecs[i].seg);
      wait_sb(0, "vec_frame");
    end

    // Mid-frame change: current frame keeps 8, next frame shows 9.
    wait_slot_start(8'h7F, "mid_align");
    set_digits(32'h12345678);
    push_frame(model_segs(32'h12345678));
    wait_sb(5, "mid_wait");
    set_digits(32'h12345679);
    push_frame(model_segs(32'h12345679));
    wait_sb(0, "mid_frame");

    // Lap hold for three frames while the counter keeps running, then release.
    wait_slot_start(8'h7F, "hold_align");
    set_digits(32'h00001000);
    push_frame(model_segs(32'h00001000));
    wait_sb(4, "hold_set");
    bus.i_hold = 1'b1;
    set_digits(32'h00001037);
    repeat (3) push_frame(model_segs(32'h00001000));
    wait_sb(12, "hold_run");
    set_digits(32'h00001089);
    wait_sb(4, "hold_release");
    bus.i_hold = 1'b0;
    set_digits(32'h00001152);
    push_frame(model_segs(32'h00001152));
    wait_sb(0, "hold_live");

    // Hold asserted exactly on the frame-boundary tick: old value stays.
    wait_slot_start(8'h7F, "holdtick_align");
    set_digits(32'h00002233);
    @(negedge clk);
    @(negedge clk);
    bus.i_hold = 1'b1;
    push_frame(model_segs(32'h00001152));
    wait_sb(0, "holdtick_frame");
    bus.i_hold = 1'b0;

    // Disable mid-scan, snapshot tracks inputs while disabled, re-enable gives a full slot.
    wait_slot_start(8'hFB, "dis_align");
    bus.i_en = 1'b0;
    set_digits(32'h30000000);
    @(negedge clk);
    chk("dis_an", bus.o_an, 8'hFF);
    chk("dis_seg", bus.o_seg, 7'h7F);
    chk("dis_dp", bus.o_dp, 1'b1);
    @(negedge clk);
    bus.i_en = 1'b1;
    @(negedge clk);
    chk("reen_an", bus.o_an, 8'hFE);
    chk("reen_seg", bus.o_seg, 7'h30);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_an !== 8'hFE) break;
      n++;
    end
    chk("reen_slot_len", n, SCAN_DIV);

    // Asynchronous reset mid-slot, then release with hold: zero snapshot is shown.
    wait_slot_start(8'hEF, "rst_align");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", bus.o_an, 8'hFF);
    chk("async_rst_seg", bus.o_seg, 7'h7F);
    chk("async_rst_dp", bus.o_dp, 1'b1);
    bus.i_hold = 1'b1;
    set_digits(32'h98765432);
    @(negedge clk);
    push_frame({7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    rst_n = 1'b1;
    wait_sb(0, "rst_frame");
    bus.i_hold = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
